fifo_reader: RTL

Read-side controller for the team's 8-entry synchronous FIFO. It drains a requested burst of words by issuing single-cycle read requests against the FIFO's empty/ack/error handshake. Each returned word is presented to a downstream consumer over a valid/ready interface. It sits between the FIFO's read port and any consumer that cannot tolerate the FIFO's one-cycle read-data timing, and it is the counterpart of the write-side logic that fills the FIFO.

---
 rtl/fifo_reader.sv | 116 +++++++++++
 1 files changed

// File: rtl/fifo_reader.sv
`default_nettype none
// ==========================================================================
// fifo_reader : burst read controller for an 8-entry synchronous FIFO
// Rev 1.0
// ==========================================================================
module fifo_reader #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [3:0]            burst_len,
  input  logic                  abort,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_rd_ack,
  input  logic                  fifo_rd_err,
  output logic                  fifo_rd_en,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  underrun,
  output logic [3:0]            words_read
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_len;
  logic [3:0]            r_words;
  logic                  r_underrun;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;

  logic       w_accept;
  logic       w_abort;
  logic       w_handshake;
  logic [3:0] w_len_clamped;
  logic [3:0] w_words_inc;

  assign w_accept      = (r_state == S_IDLE) && start && !abort;
  assign w_abort       = (r_state != S_IDLE) && abort;
  assign w_handshake   = (r_state == S_HOLD) && r_out_valid && out_ready;
  assign w_len_clamped = (burst_len > 4'd8) ? 4'd8 : burst_len;
  assign w_words_inc   = r_words + 4'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (w_len_clamped == 4'd0) ? S_DONE : S_REQ;
      S_REQ:  if (!fifo_empty) w_next = S_WAIT;
      S_WAIT: begin
        if (fifo_rd_ack)      w_next = S_HOLD;
        else if (fifo_rd_err) w_next = S_REQ;
      end
      S_HOLD: if (w_handshake) w_next = (w_words_inc == r_len) ? S_DONE : S_REQ;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // Abort overrides every other transition outside IDLE.
    if (w_abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len       <= 4'd0;
      r_words     <= 4'd0;
      r_underrun  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept) begin
      r_len      <= w_len_clamped;
      r_words    <= 4'd0;
      r_underrun <= 1'b0;
    end else if (w_abort) begin
      r_out_valid <= 1'b0;
    end else if (r_state == S_WAIT) begin
      if (fifo_rd_ack) begin
        r_out_data  <= fifo_dout;
        r_out_valid <= 1'b1;
      end
      // An error alongside an ack still marks the burst as underrun.
      if (fifo_rd_err) r_underrun <= 1'b1;
    end else if (w_handshake) begin
      r_out_valid <= 1'b0;
      r_words     <= w_words_inc;
    end
  end

  assign fifo_rd_en = (r_state == S_REQ) && !fifo_empty;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign underrun   = r_underrun;
  assign words_read = r_words;

endmodule
`default_nettype wire
